config_sequencer: RTL and testbench
===================================

# config_sequencer

Configuration bus master that drives the `config_we`/`config_data` write port of `RegisterMode`-style configurable registers and reads them back. It accepts write and read commands over a valid/ready command channel, issues single-cycle write or read strobes on an addressed configuration bus, and returns read data over a valid/ready response channel. It sits between the bitstream loader/host interface and the array of configurable registers.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, configuration address width.
- `DATA_WIDTH`, 4, configuration data width (matches the target register width).
- `READ_LATENCY`, 1, cycles from `config_re` high to valid `config_rdata`; legal range 1..15.

Ports:
- `CLK`  in  1  clock, all state updates on the rising edge.
- `ASYNCRESETN`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  1  0 = write, 1 = read.
- `cmd_addr`  in  ADDR_WIDTH  target address.
- `cmd_data`  in  DATA_WIDTH  write data; ignored for reads.
- `config_addr`  out  ADDR_WIDTH  bus address; targets decode it.
- `config_data`  out  DATA_WIDTH  bus write data.
- `config_we`  out  1  write strobe, one cycle per write.
- `config_re`  out  1  read strobe, one cycle per read.
- `config_rdata`  in  DATA_WIDTH  read data from the addressed target.
- `rsp_valid`  out  1  read response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_addr`  out  ADDR_WIDTH  address of the read being returned.
- `rsp_data`  out  DATA_WIDTH  captured read data.
- `busy`  out  1  high in every state except IDLE.
- `wr_count`  out  8  completed writes, wraps modulo 256.

## Operation
- FSM states: IDLE, WRITE, READ, WAIT, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch `cmd_addr` into `config_addr` and `cmd_data` into `config_data`, store the address for `rsp_addr`, then go to WRITE (`cmd_op`=0) or READ (`cmd_op`=1).
- WRITE: `config_we`=1 for exactly this cycle. Increment `wr_count` at the exiting edge, then go to IDLE.
- READ: `config_re`=1 for exactly this cycle. Load the wait counter with `READ_LATENCY`-1, then go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, capture `config_rdata` into `rsp_data` and go to RESP.
- RESP: `rsp_valid`=1. `rsp_data` and `rsp_addr` are held stable until `rsp_ready`=1, then go to IDLE.
- `cmd_ready` is 0 in every state other than IDLE. A command is never accepted while a response is pending.
- `config_addr` and `config_data` hold their last latched values between commands. `config_we` and `config_re` are never high together.
- Reset values: state IDLE, `cmd_ready`=1, `config_we`=0, `config_re`=0, `rsp_valid`=0, `busy`=0. `config_addr`, `config_data`, `rsp_addr`, `rsp_data` and `wr_count` are all 0.
- Reset asserted mid-operation: immediate return to the reset values. Any in-flight write strobe or pending response is dropped and does not count.

## Timing
Cycle numbering: the command is accepted at rising edge 0, and cycle n is the interval following edge n-1.
- Write: `config_we`=1 in cycle 1 and is sampled by the target at edge 1. `wr_count` updates at edge 1. `cmd_ready`=1 again in cycle 2, giving a maximum throughput of one write per 2 cycles.
- Read: `config_re`=1 in cycle 1. `config_rdata` is captured at edge `READ_LATENCY`+1. `rsp_valid`=1 from cycle `READ_LATENCY`+2.
  - With `READ_LATENCY`=1 and `rsp_ready` tied high, `rsp_valid` is high for one cycle (cycle 3) and `cmd_ready`=1 in cycle 4.
- `cmd_valid` held while `cmd_ready`=0 has no effect. The command is accepted at the first edge where `cmd_ready`=1.
- `wr_count` at 255 plus one write gives 0, with no flag.

## Test plan
- After reset, one write (addr 0x05, data 0xA): `config_we` high for exactly one cycle with `config_addr`=0x05 and `config_data`=0xA; `wr_count`=1; `cmd_ready` low for 1 cycle only.
- Write 0x3 to addr 0x02, then read addr 0x02, with a model target holding the value (`READ_LATENCY`=1): `config_re` pulses once; `rsp_valid` high in cycle 3 after read acceptance; `rsp_data`=0x3, `rsp_addr`=0x02.
- Read with `rsp_ready` held low for 5 cycles: `rsp_valid` and `rsp_data` remain stable; `cmd_ready` stays 0; a new `cmd_valid` is not accepted until the cycle after the `rsp_ready` handshake.
- `READ_LATENCY`=3, target data appears only 3 cycles after `config_re`: the correct value is captured and `rsp_valid` rises in cycle 5.
- 257 back-to-back writes with `cmd_valid` held high: one `config_we` every 2 cycles and never adjacent; `wr_count` ends at 1.
- Assert `ASYNCRESETN` low during WAIT and again during WRITE: outputs go to their reset values asynchronously; no response is produced; `wr_count`=0 after release.

Source files
------------

// File: rtl/config_sequencer.sv
// ---------------------------------------------------------------------------
// config_sequencer
//
// Configuration bus master. Takes write/read commands over a valid/ready
// command channel, issues single-cycle write or read strobes on an addressed
// configuration bus, and returns read data over a valid/ready response
// channel.
//
// Ports:
//   CLK           clock, rising edge
//   ASYNCRESETN   asynchronous active-low reset
//   cmd_valid     command present
//   cmd_ready     sequencer can accept a command (high only in IDLE)
//   cmd_op        0 = write, 1 = read
//   cmd_addr      target address
//   cmd_data      write data (ignored for reads)
//   config_addr   bus address, held between commands
//   config_data   bus write data, held between commands
//   config_we     one-cycle write strobe
//   config_re     one-cycle read strobe
//   config_rdata  read data from the addressed target
//   rsp_valid     read response present
//   rsp_ready     consumer accepts the response
//   rsp_addr      address of the read being returned
//   rsp_data      captured read data
//   busy          high in every state except IDLE
//   wr_count      completed writes, modulo 256
// ---------------------------------------------------------------------------
module config_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 4,
    parameter int READ_LATENCY = 1   // legal range 1..15
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [ADDR_WIDTH-1:0] config_addr,
    output logic [DATA_WIDTH-1:0] config_data,
    output logic                  config_we,
    output logic                  config_re,
    input  logic [DATA_WIDTH-1:0] config_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic [7:0]            wr_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // The READ cycle itself accounts for one cycle of latency, so the wait
    // counter starts one below READ_LATENCY and the capture happens when it
    // reaches zero.
    localparam logic [3:0] LP_WAIT_LOAD = 4'(READ_LATENCY - 1);

    state_t                r_state;
    logic [3:0]            r_wait_cnt;
    logic                  r_cmd_ready;
    logic                  r_we;
    logic                  r_re;
    logic                  r_rsp_valid;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_cfg_addr;
    logic [DATA_WIDTH-1:0] r_cfg_data;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [7:0]            r_wr_count;

    // All outputs are registered and updated together with the state so that
    // each one is exactly a decode of the state being entered.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_cmd_ready <= 1'b1;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_wr_count  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cfg_addr  <= cmd_addr;
                        r_cfg_data  <= cmd_data;
                        r_rsp_addr  <= cmd_addr;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_op) begin
                            r_state <= S_READ;
                            r_re    <= 1'b1;
                        end else begin
                            r_state <= S_WRITE;
                            r_we    <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    // The write counts as complete only when the strobe has
                    // been presented for its full cycle.
                    r_we        <= 1'b0;
                    r_wr_count  <= r_wr_count + 8'd1;
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end

                S_READ: begin
                    r_re       <= 1'b0;
                    r_wait_cnt <= LP_WAIT_LOAD;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_rsp_data  <= config_rdata;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_we        <= 1'b0;
                    r_re        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign config_addr = r_cfg_addr;
    assign config_data = r_cfg_data;
    assign config_we   = r_we;
    assign config_re   = r_re;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_addr    = r_rsp_addr;
    assign rsp_data    = r_rsp_data;
    assign busy        = r_busy;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_config_sequencer
//
// Directed bench for config_sequencer. Two instances share clock and reset:
// dut1 with READ_LATENCY=1 and dut3 with READ_LATENCY=3. Each has a small
// target model: a register array written on config_we, and a read path that
// shows the stored value only in the cycle READ_LATENCY cycles after
// config_re (the inverted value otherwise), so a capture at the wrong edge
// returns wrong data.
// ---------------------------------------------------------------------------
module tb_config_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- dut1 (READ_LATENCY = 1) ----------------
    logic       c1_valid, c1_ready, c1_op;
    logic [7:0] c1_addr;
    logic [3:0] c1_data;
    logic [7:0] b1_addr;
    logic [3:0] b1_data, b1_rdata;
    logic       b1_we, b1_re;
    logic       r1_valid, r1_ready;
    logic [7:0] r1_addr;
    logic [3:0] r1_data;
    logic       busy1;
    logic [7:0] wrc1;

    config_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(4), .READ_LATENCY(1)) dut1 (
        .CLK(clk), .ASYNCRESETN(rst_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_op(c1_op),
        .cmd_addr(c1_addr), .cmd_data(c1_data),
        .config_addr(b1_addr), .config_data(b1_data),
        .config_we(b1_we), .config_re(b1_re), .config_rdata(b1_rdata),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready),
        .rsp_addr(r1_addr), .rsp_data(r1_data),
        .busy(busy1), .wr_count(wrc1)
    );

    logic [3:0] mem1 [256];
    logic [2:0] sr1 = 3'b000;
    logic [3:0] lat1 = 4'h0;
    always @(posedge clk) begin
        if (b1_we) mem1[b1_addr] <= b1_data;
        sr1 <= {sr1[1:0], b1_re};
        if (b1_re) lat1 <= mem1[b1_addr];
    end
    assign b1_rdata = sr1[0] ? lat1 : ~lat1;

    // ---------------- dut3 (READ_LATENCY = 3) ----------------
    logic       c3_valid, c3_ready, c3_op;
    logic [7:0] c3_addr;
    logic [3:0] c3_data;
    logic [7:0] b3_addr;
    logic [3:0] b3_data, b3_rdata;
    logic       b3_we, b3_re;
    logic       r3_valid, r3_ready;
    logic [7:0] r3_addr;
    logic [3:0] r3_data;
    logic       busy3;
    logic [7:0] wrc3;

    config_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(4), .READ_LATENCY(3)) dut3 (
        .CLK(clk), .ASYNCRESETN(rst_n),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op),
        .cmd_addr(c3_addr), .cmd_data(c3_data),
        .config_addr(b3_addr), .config_data(b3_data),
        .config_we(b3_we), .config_re(b3_re), .config_rdata(b3_rdata),
        .rsp_valid(r3_valid), .rsp_ready(r3_ready),
        .rsp_addr(r3_addr), .rsp_data(r3_data),
        .busy(busy3), .wr_count(wrc3)
    );

    logic [3:0] mem3 [256];
    logic [2:0] sr3 = 3'b000;
    logic [3:0] lat3 = 4'h0;
    always @(posedge clk) begin
        if (b3_we) mem3[b3_addr] <= b3_data;
        sr3 <= {sr3[1:0], b3_re};
        if (b3_re) lat3 <= mem3[b3_addr];
    end
    assign b3_rdata = sr3[2] ? lat3 : ~lat3;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pulses;
    int adj;
    int both;
    int seen;
    logic prev_we;

    initial begin
        c1_valid = 1'b0; c1_op = 1'b0; c1_addr = 8'h00; c1_data = 4'h0; r1_ready = 1'b1;
        c3_valid = 1'b0; c3_op = 1'b0; c3_addr = 8'h00; c3_data = 4'h0; r3_ready = 1'b1;

        // ---- reset values ----
        rst_n = 1'b0;
        tick(); tick(); tick();
        chk("rst_cmd_ready",   32'(c1_ready), 32'd1);
        chk("rst_config_we",   32'(b1_we),    32'd0);
        chk("rst_config_re",   32'(b1_re),    32'd0);
        chk("rst_rsp_valid",   32'(r1_valid), 32'd0);
        chk("rst_busy",        32'(busy1),    32'd0);
        chk("rst_config_addr", 32'(b1_addr),  32'd0);
        chk("rst_config_data", 32'(b1_data),  32'd0);
        chk("rst_rsp_addr",    32'(r1_addr),  32'd0);
        chk("rst_rsp_data",    32'(r1_data),  32'd0);
        chk("rst_wr_count",    32'(wrc1),     32'd0);
        rst_n = 1'b1;
        tick();

        // ---- single write 0x05 <= 0xA ----
        c1_valid = 1'b1; c1_op = 1'b0; c1_addr = 8'h05; c1_data = 4'hA;
        tick();                                   // cycle 1
        c1_valid = 1'b0;
        chk("wr1_we_c1",    32'(b1_we),    32'd1);
        chk("wr1_addr_c1",  32'(b1_addr),  32'h05);
        chk("wr1_data_c1",  32'(b1_data),  32'hA);
        chk("wr1_ready_c1", 32'(c1_ready), 32'd0);
        chk("wr1_busy_c1",  32'(busy1),    32'd1);
        chk("wr1_re_c1",    32'(b1_re),    32'd0);
        tick();                                   // cycle 2
        chk("wr1_we_c2",    32'(b1_we),    32'd0);
        chk("wr1_count",    32'(wrc1),     32'd1);
        chk("wr1_ready_c2", 32'(c1_ready), 32'd1);
        chk("wr1_busy_c2",  32'(busy1),    32'd0);
        chk("wr1_hold_addr", 32'(b1_addr), 32'h05);

        // ---- write 0x02 <= 0x3, then read it back ----
        c1_valid = 1'b1; c1_op = 1'b0; c1_addr = 8'h02; c1_data = 4'h3;
        tick();
        c1_valid = 1'b0;
        tick();
        chk("wr2_count", 32'(wrc1), 32'd2);
        c1_valid = 1'b1; c1_op = 1'b1; c1_addr = 8'h02; c1_data = 4'hF;
        tick();                                   // cycle 1
        c1_valid = 1'b0;
        chk("rd1_re_c1",    32'(b1_re),    32'd1);
        chk("rd1_we_c1",    32'(b1_we),    32'd0);
        chk("rd1_ready_c1", 32'(c1_ready), 32'd0);
        tick();                                   // cycle 2
        chk("rd1_re_c2",    32'(b1_re),    32'd0);
        chk("rd1_valid_c2", 32'(r1_valid), 32'd0);
        tick();                                   // cycle 3
        chk("rd1_valid_c3", 32'(r1_valid), 32'd1);
        chk("rd1_data",     32'(r1_data),  32'h3);
        chk("rd1_addr",     32'(r1_addr),  32'h02);
        chk("rd1_ready_c3", 32'(c1_ready), 32'd0);
        tick();                                   // cycle 4
        chk("rd1_valid_c4", 32'(r1_valid), 32'd0);
        chk("rd1_ready_c4", 32'(c1_ready), 32'd1);

        // ---- read 0x05 with rsp_ready low for 5 cycles ----
        r1_ready = 1'b0;
        c1_valid = 1'b1; c1_op = 1'b1; c1_addr = 8'h05;
        tick();                                   // cycle 1
        // A write command is now held pending; it must wait for the handshake.
        c1_op = 1'b0; c1_addr = 8'h11; c1_data = 4'h6;
        tick(); tick();                           // cycle 3
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), 32'(r1_valid), 32'd1);
            chk($sformatf("bp_data_%0d", k),  32'(r1_data),  32'hA);
            chk($sformatf("bp_addr_%0d", k),  32'(r1_addr),  32'h05);
            chk($sformatf("bp_ready_%0d", k), 32'(c1_ready), 32'd0);
            chk($sformatf("bp_we_%0d", k),    32'(b1_we),    32'd0);
            tick();
        end
        r1_ready = 1'b1;                          // cycle 8
        chk("bp_valid_hs", 32'(r1_valid), 32'd1);
        tick();                                   // cycle 9: back in IDLE
        chk("bp_idle_ready", 32'(c1_ready), 32'd1);
        chk("bp_idle_valid", 32'(r1_valid), 32'd0);
        chk("bp_idle_we",    32'(b1_we),    32'd0);
        tick();                                   // cycle 10: pending write taken
        c1_valid = 1'b0;
        chk("bp_wr_we",   32'(b1_we),   32'd1);
        chk("bp_wr_addr", 32'(b1_addr), 32'h11);
        tick();
        chk("bp_wr_count", 32'(wrc1), 32'd3);

        // ---- READ_LATENCY = 3: write 0x33 <= 0x9, read it back ----
        c3_valid = 1'b1; c3_op = 1'b0; c3_addr = 8'h33; c3_data = 4'h9;
        tick();
        c3_valid = 1'b0;
        tick();
        c3_valid = 1'b1; c3_op = 1'b1; c3_addr = 8'h33;
        tick();                                   // cycle 1
        c3_valid = 1'b0;
        chk("rl3_re_c1", 32'(b3_re), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("rl3_valid_c%0d", c), 32'(r3_valid), 32'd0);
        end
        tick();                                   // cycle 5
        chk("rl3_valid_c5", 32'(r3_valid), 32'd1);
        chk("rl3_data",     32'(r3_data),  32'h9);
        chk("rl3_addr",     32'(r3_addr),  32'h33);
        tick();                                   // cycle 6
        chk("rl3_ready_c6", 32'(c3_ready), 32'd1);

        // ---- reset asserted during WAIT ----
        c1_valid = 1'b1; c1_op = 1'b1; c1_addr = 8'h02;
        tick();                                   // cycle 1 READ
        c1_valid = 1'b0;
        tick();                                   // cycle 2 WAIT
        chk("rw_busy_pre", 32'(busy1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_busy",      32'(busy1),    32'd0);
        chk("rw_cmd_ready", 32'(c1_ready), 32'd1);
        chk("rw_rsp_valid", 32'(r1_valid), 32'd0);
        chk("rw_addr",      32'(b1_addr),  32'd0);
        chk("rw_rsp_addr",  32'(r1_addr),  32'd0);
        chk("rw_wr_count",  32'(wrc1),     32'd0);
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (r1_valid) seen++;
        end
        chk("rw_no_response", 32'(seen), 32'd0);
        chk("rw_rsp_data",    32'(r1_data), 32'd0);

        // ---- reset asserted during WRITE ----
        c1_valid = 1'b1; c1_op = 1'b0; c1_addr = 8'h22; c1_data = 4'h5;
        tick();                                   // cycle 1 WRITE
        c1_valid = 1'b0;
        chk("rwr_we_pre", 32'(b1_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rwr_we",    32'(b1_we),    32'd0);
        chk("rwr_addr",  32'(b1_addr),  32'd0);
        chk("rwr_data",  32'(b1_data),  32'd0);
        chk("rwr_busy",  32'(busy1),    32'd0);
        chk("rwr_ready", 32'(c1_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("rwr_wr_count", 32'(wrc1), 32'd0);

        // ---- 257 back-to-back writes ----
        pulses = 0; adj = 0; both = 0; prev_we = 1'b0;
        c1_valid = 1'b1; c1_op = 1'b0;
        for (int t = 1; t <= 513; t++) begin
            c1_addr = 8'(t);
            c1_data = 4'(t);
            tick();
            if (b1_we) pulses++;
            if (b1_we && prev_we) adj++;
            if (b1_we && b1_re) both++;
            prev_we = b1_we;
            if (t == 512) chk("b2b_wrap_256", 32'(wrc1), 32'd0);
        end
        c1_valid = 1'b0;
        tick();
        if (b1_we) pulses++;
        chk("b2b_pulses",   32'(pulses), 32'd257);
        chk("b2b_adjacent", 32'(adj),    32'd0);
        chk("b2b_we_re",    32'(both),   32'd0);
        chk("b2b_count",    32'(wrc1),   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
